// File: rtl/vga_stream_sink.sv
// -----------------------------------------------------------------------------
// vga_stream_sink
//
// Bridges a valid/ready pixel stream (with start-of-packet framing) onto a VGA
// timing generator. Incoming pixels are discarded until a start-of-packet beat
// arrives. Buffered pixels then wait for the next VGA frame_start. After that,
// one pixel is popped on every active-video cycle.
//
// Ports
//   clk               pixel clock, rising edge
//   reset             synchronous, active-high
//   data_in           pixel from the upstream stage
//   valid_in          data_in is valid
//   startofpacket_in  first pixel of a frame
//   ready_out         sink accepts a beat this cycle (combinational)
//   visible           VGA active-video indicator
//   frame_start       one-cycle pulse at the start of each VGA frame
//   pixel_out         registered pixel; 0 on cycles that did not pop
//   level             FIFO occupancy, 0..DEPTH
//   underflow         sticky: active video arrived while the FIFO was empty
//   underflow_count   saturating count of underflow cycles
//   frame_err         one-cycle pulse: the previous frame popped the wrong count
// -----------------------------------------------------------------------------
module vga_stream_sink #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int IMG_W  = 640,
   parameter int IMG_H  = 480
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [DATA_W-1:0]          data_in,
   input  logic                       valid_in,
   input  logic                       startofpacket_in,
   output logic                       ready_out,
   input  logic                       visible,
   input  logic                       frame_start,
   output logic [DATA_W-1:0]          pixel_out,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       underflow,
   output logic [15:0]                underflow_count,
   output logic                       frame_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [19:0] FRAME_PIXELS = 20'(IMG_W * IMG_H);

   typedef enum logic [1:0] {
      DROP,
      WAIT_FRAME,
      STREAM
   } state_t;

   state_t            state;
   state_t            state_nxt;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;

   logic              fifo_full;
   logic              fifo_empty;
   logic              accept;
   logic              do_write;
   logic              do_pop;
   logic              do_uf;

   logic [19:0]       pop_cnt;
   // Set from reset until the first frame_start seen in STREAM. The frame that
   // precedes it started mid-stream, so its count is not checked.
   logic              first_fs_pending;

   assign fifo_full  = (level == LW'(DEPTH));
   assign fifo_empty = (level == '0);

   // ---------------------------------------------------------------------------
   // Next-state and datapath strobes
   // ---------------------------------------------------------------------------
   // NOTE: every signal driven here gets a default first, so no path through
   // the case statement can leave a value held (which would infer a latch).
   always_comb begin
      state_nxt = state;
      ready_out = fifo_full ? 1'b0 : 1'b1;
      do_write  = 1'b0;
      do_pop    = 1'b0;
      do_uf     = 1'b0;

      // DROP must drain the upstream, so it always accepts.
      if (state == DROP) ready_out = 1'b1;
      accept = valid_in & ready_out;

      case (state)
         DROP: begin
            if (accept && startofpacket_in) begin
               do_write  = !fifo_full;
               state_nxt = WAIT_FRAME;
            end
         end
         WAIT_FRAME: begin
            do_write = accept;
            if (frame_start) state_nxt = STREAM;
         end
         STREAM: begin
            do_write = accept;
            // A beat written this cycle cannot satisfy this cycle's read.
            do_pop   = visible & !fifo_empty;
            do_uf    = visible &  fifo_empty;
         end
         default: state_nxt = DROP;
      endcase
   end

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of process ordering.
   always_ff @(posedge clk) begin
      if (reset) state <= DROP;
      else       state <= state_nxt;
   end

   // ---------------------------------------------------------------------------
   // FIFO storage
   // ---------------------------------------------------------------------------
   // NOTE: the storage array has no reset. Pointers and level define which
   // entries are live, so clearing them flushes the FIFO. Leaving the array
   // unreset lets it map onto plain RAM.
   always_ff @(posedge clk) begin
      if (do_write) mem[wr_ptr] <= data_in;
   end

   // ---------------------------------------------------------------------------
   // Pointers, occupancy and output pixel
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         pixel_out <= '0;
      end else begin
         // Pointers are exactly AW bits wide, so they wrap modulo DEPTH.
         if (do_write) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)   rd_ptr <= rd_ptr + 1'b1;

         case ({do_write, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase

         pixel_out <= do_pop ? mem[rd_ptr] : '0;
      end
   end

   // ---------------------------------------------------------------------------
   // Underflow tracking (cleared only by reset)
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         underflow       <= 1'b0;
         underflow_count <= '0;
      end else if (do_uf) begin
         underflow <= 1'b1;
         if (underflow_count != 16'hFFFF) underflow_count <= underflow_count + 16'd1;
      end
   end

   // ---------------------------------------------------------------------------
   // Per-frame pixel accounting
   // ---------------------------------------------------------------------------
   // Every active-video cycle in STREAM counts, whether it popped a pixel or
   // underflowed, so the count tracks what the display consumed.
   always_ff @(posedge clk) begin
      if (reset) begin
         pop_cnt          <= '0;
         first_fs_pending <= 1'b1;
         frame_err        <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         if (state == STREAM) begin
            if (frame_start) begin
               frame_err        <= !first_fs_pending && (pop_cnt != FRAME_PIXELS);
               first_fs_pending <= 1'b0;
               // The frame_start cycle is the first cycle of the new frame.
               pop_cnt          <= (do_pop | do_uf) ? 20'd1 : 20'd0;
            end else if (do_pop | do_uf) begin
               pop_cnt <= pop_cnt + 20'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_vga_stream_sink.sv
// -----------------------------------------------------------------------------
// tb_vga_stream_sink
//
// Self-checking bench for vga_stream_sink using a small image (8x4) so that
// whole frames fit in a short run. A queue-based reference model predicts the
// post-edge outputs of each cycle and pushes them to a scoreboard. A monitor
// pops the predictions and compares them after every rising edge.
// -----------------------------------------------------------------------------
module tb_vga_stream_sink;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 16;
   localparam int IMG_W  = 8;
   localparam int IMG_H  = 4;
   localparam int FRAME  = IMG_W * IMG_H;
   localparam int LW     = $clog2(DEPTH) + 1;

   logic              clk = 1'b0;
   logic              reset;
   logic [DATA_W-1:0] data_in;
   logic              valid_in;
   logic              startofpacket_in;
   logic              ready_out;
   logic              visible;
   logic              frame_start;
   logic [DATA_W-1:0] pixel_out;
   logic [LW-1:0]     level;
   logic              underflow;
   logic [15:0]       underflow_count;
   logic              frame_err;

   vga_stream_sink #(
      .DATA_W(DATA_W), .DEPTH(DEPTH), .IMG_W(IMG_W), .IMG_H(IMG_H)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .data_in          (data_in),
      .valid_in         (valid_in),
      .startofpacket_in (startofpacket_in),
      .ready_out        (ready_out),
      .visible          (visible),
      .frame_start      (frame_start),
      .pixel_out        (pixel_out),
      .level            (level),
      .underflow        (underflow),
      .underflow_count  (underflow_count),
      .frame_err        (frame_err)
   );

   always #5 clk = ~clk;

   // ---------------------------------------------------------------------------
   // Scoreboard bookkeeping
   // ---------------------------------------------------------------------------
   typedef struct {
      logic [DATA_W-1:0] pix;
      int                lvl;
      logic              uf;
      int                ucnt;
      logic              ferr;
      logic              rdy;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp     = 0;
   int   n_bad     = 0;
   int   ferr_seen = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model: the FIFO is a queue; the block is either unsynchronised,
   // synchronised but waiting for a VGA frame, or streaming.
   // ---------------------------------------------------------------------------
   logic [DATA_W-1:0] m_fifo[$];
   bit                m_synced;
   bit                m_stream;
   bit                m_seen_fs;
   int                m_cnt;
   logic [DATA_W-1:0] m_pix;
   bit                m_uf;
   int                m_ucnt;
   int                m_ferr_total = 0;

   // Drive one cycle of inputs, advance the model by one clock and queue the
   // outputs the DUT must show after that clock edge.
   task automatic step(input bit rst, input bit v, input bit sop,
                       input logic [DATA_W-1:0] d, input bit vis, input bit fs);
      exp_t e;
      bit   ferr_now = 1'b0;
      @(negedge clk);
      reset            = rst;
      valid_in         = v;
      startofpacket_in = sop;
      data_in          = d;
      visible          = vis;
      frame_start      = fs;

      if (rst) begin
         m_fifo.delete();
         m_synced  = 1'b0;
         m_stream  = 1'b0;
         m_seen_fs = 1'b0;
         m_cnt     = 0;
         m_pix     = '0;
         m_uf      = 1'b0;
         m_ucnt    = 0;
      end else begin
         int size0 = m_fifo.size();
         bit rdy   = !m_synced || (size0 < DEPTH);
         bit acc   = v && rdy;
         bit need  = m_stream && vis;
         bit got   = need && (size0 > 0);
         m_pix = '0;
         if (got) m_pix = m_fifo.pop_front();
         if (acc && (m_synced || sop) && size0 < DEPTH) m_fifo.push_back(d);
         if (need && !got) begin
            m_uf = 1'b1;
            if (m_ucnt < 16'hFFFF) m_ucnt++;
         end
         if (m_stream) begin
            if (fs) begin
               ferr_now  = m_seen_fs && (m_cnt != FRAME);
               m_seen_fs = 1'b1;
               m_cnt     = need ? 1 : 0;
            end else if (need) begin
               m_cnt++;
            end
         end
         if (ferr_now) m_ferr_total++;
         if (!m_synced && acc && sop)      m_synced = 1'b1;
         else if (m_synced && !m_stream && fs) m_stream = 1'b1;
      end

      e.pix  = m_pix;
      e.lvl  = m_fifo.size();
      e.uf   = m_uf;
      e.ucnt = m_ucnt;
      e.ferr = ferr_now;
      e.rdy  = !m_synced || (m_fifo.size() < DEPTH);
      exp_q.push_back(e);
   endtask

   // ---------------------------------------------------------------------------
   // Monitor: compare every predicted cycle just after the rising edge.
   // ---------------------------------------------------------------------------
   always @(posedge clk) begin
      #1;
      if (exp_q.size() != 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check("pixel_out",       32'(pixel_out),       32'(e.pix));
         check("level",           32'(level),           32'(e.lvl));
         check("underflow",       32'(underflow),       32'(e.uf));
         check("underflow_count", 32'(underflow_count), 32'(e.ucnt));
         check("frame_err",       32'(frame_err),       32'(e.ferr));
         check("ready_out",       32'(ready_out),       32'(e.rdy));
         if (frame_err) ferr_seen++;
      end
   end

   // Wait for the edge that follows the last step, then look at the outputs.
   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0, 0);
   endtask

   // One VGA frame: frame_start on a blanking cycle, n_vis active cycles with a
   // beat offered every cycle, then a short blanking gap.
   task automatic frame(input int n_vis);
      step(0, 1, 0, DATA_W'($urandom_range(0, 255)), 0, 1);
      for (int i = 0; i < n_vis; i++) step(0, 1, 0, DATA_W'($urandom_range(0, 255)), 1, 0);
      for (int i = 0; i < 3; i++) step(0, $urandom_range(0, 1) == 1, 0, DATA_W'($urandom_range(0, 255)), 0, 0);
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      int ferr_base;
      int wait_cnt;
      reset = 1'b1; valid_in = 1'b0; startofpacket_in = 1'b0;
      data_in = '0; visible = 1'b0; frame_start = 1'b0;

      step(1, 0, 0, '0, 0, 0);
      step(1, 1, 1, 8'h5A, 1, 1);

      // Five beats without start-of-packet are dropped; SOP 0x11 then 0x22 kept.
      for (int i = 0; i < 5; i++) step(0, 1, 0, DATA_W'($urandom_range(0, 255)), 0, 0);
      step(0, 1, 1, 8'h11, 0, 0);
      step(0, 1, 0, 8'h22, 0, 0);
      settle();
      check("sync_level_2", 32'(level), 32'd2);

      // frame_start is ignored in DROP only; here a stray SOP must be stored.
      step(0, 1, 1, 8'h33, 0, 0);

      // Keep offering beats with no frame_start until the FIFO fills.
      for (int i = 0; i < 20; i++) step(0, 1, 0, DATA_W'($urandom_range(0, 255)), 0, 0);
      settle();
      check("full_ready_low", 32'(ready_out), 32'd0);
      check("full_level",     32'(level),     32'(DEPTH));

      // Enter STREAM, pop once while still offering beats, then drain fully.
      step(0, 1, 0, 8'hEE, 0, 1);
      step(0, 1, 0, 8'hEF, 1, 0);
      step(0, 1, 0, 8'hF0, 0, 0);
      while (m_fifo.size() > 0) step(0, 0, 0, '0, 1, 0);

      // A single 0xA5 shows one cycle after its pop, then 0.
      step(0, 1, 0, 8'hA5, 0, 0);
      step(0, 0, 0, '0, 1, 0);
      settle();
      check("a5_pixel", 32'(pixel_out), 32'hA5);
      step(0, 0, 0, '0, 0, 0);

      // Three active cycles on an empty FIFO.
      for (int i = 0; i < 3; i++) step(0, 0, 0, '0, 1, 0);
      settle();
      check("uf_count_3", 32'(underflow_count), 32'd3);
      check("uf_flag",    32'(underflow),       32'd1);
      check("uf_pixel",   32'(pixel_out),       32'd0);

      // Underflow with a same-cycle beat: the beat is stored, the read still fails.
      step(0, 1, 0, 8'h77, 1, 0);
      step(0, 0, 0, '0, 1, 0);

      // Frames: an exact frame, then one pixel short.
      for (int i = 0; i < 4; i++) step(0, 1, 0, DATA_W'($urandom_range(0, 255)), 0, 0);
      ferr_base = ferr_seen;
      frame(FRAME);
      frame(FRAME);
      frame(FRAME - 1);
      step(0, 0, 0, '0, 0, 1);
      idle(2);
      check("frame_err_pulses", 32'(ferr_seen - ferr_base), 32'd1);

      // Bring the FIFO to exactly nine entries, then reset for one cycle.
      while (m_fifo.size() > 0) step(0, 0, 0, '0, 1, 0);
      for (int i = 0; i < 9; i++) step(0, 1, 0, DATA_W'($urandom_range(0, 255)), 0, 0);
      settle();
      check("pre_reset_level_9", 32'(level), 32'd9);
      step(1, 0, 0, '0, 0, 0);
      settle();
      check("rst_level",     32'(level),           32'd0);
      check("rst_pixel",     32'(pixel_out),       32'd0);
      check("rst_underflow", 32'(underflow),       32'd0);
      check("rst_ucount",    32'(underflow_count), 32'd0);
      check("rst_ready",     32'(ready_out),       32'd1);
      for (int i = 0; i < 4; i++) step(0, 1, 0, DATA_W'($urandom_range(0, 255)), 1, 1);

      // Randomised soak with occasional resets.
      for (int i = 0; i < 4000; i++) begin
         step($urandom_range(0, 299) == 0,
              $urandom_range(0, 9) < 7,
              $urandom_range(0, 19) == 0,
              DATA_W'($urandom_range(0, 255)),
              $urandom_range(0, 9) < 6,
              $urandom_range(0, 39) == 0);
      end
      idle(3);

      wait_cnt = 0;
      while (exp_q.size() != 0 && wait_cnt < 20) begin
         @(posedge clk);
         wait_cnt++;
      end
      #2;
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      check("frame_err_total",    32'(ferr_seen),    32'(m_ferr_total));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
